bexkat2_busarb: RTL and testbench

//  Two-master Wishbone (classic) arbiter that shares one memory/peripheral slave port between
//  the CPU instruction bus (m0) and data bus (m1). Round-robin, cycle-locked grant; per-grant

---
 rtl/bexkat2_busarb_pkg.sv | 24 ++
 rtl/bexkat2_busarb_watchdog.sv | 32 +++
 rtl/bexkat2_busarb.sv | 147 ++++++++++++++
 tb/tb_bexkat2_busarb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bexkat2_busarb_pkg.sv
// Shared types and helpers for the bexkat2 two-master Wishbone arbiter.
package bexkat2_busarb_pkg;

   // Arbiter FSM states; encoding is also the one-hot-ish grant for the two masters.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_t;

   // Identity of the master served most recently (used to break ties from IDLE).
   localparam logic LAST_M0 = 1'b0;
   localparam logic LAST_M1 = 1'b1;

   // One-hot grant vector {m1,m0} for a given arbiter state.
   function automatic logic [1:0] grant_of(input arb_state_t s);
      logic [1:0] g;
      g = 2'b00;
      if (s == ARB_GNT0) g = 2'b01;
      if (s == ARB_GNT1) g = 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/bexkat2_busarb_watchdog.sv
// Per-grant watchdog: counts strobe cycles without ack and pulses timeout_o
// for one cycle when the slave has stalled for TIMEOUT strobe cycles.
module bexkat2_busarb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,      // grant change or slave ack
   input  logic en_i,       // granted strobe is active
   output logic timeout_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // The pulse fires on the last allowed stall cycle, even if a late ack shows up then.
   assign timeout_o = en_i && (count_q == LAST);

   // Stall counter: any clear condition wins over increment.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clr_i || !en_i || timeout_o) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/bexkat2_busarb.sv
// Two-master Wishbone classic arbiter (m0 = instruction bus, m1 = data bus).
// Round-robin, cycle-locked grant with a registered grant and a per-grant watchdog.
// Handshake: a master owns the slave from the cycle after its cyc is seen until the
// cycle its cyc falls; stb/ack follow Wishbone classic (ack only to the granted master,
// err replaces ack for one cycle when the watchdog fires).
module bexkat2_busarb
   import bexkat2_busarb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // instruction master
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // data master
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // shared slave port
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   // status
   output logic [1:0]      gnt_o,
   output logic [1:0]      state_o
);

   arb_state_t state_q, state_d;
   logic       last_q;
   logic       stb_raw;
   logic       timeout;

   // Next grant: hold while the owner keeps cyc, hand over directly, tie-break on last served.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = (last_q == LAST_M1) ? ARB_GNT0 : ARB_GNT1;
            else if (m0_cyc_i)        state_d = ARB_GNT0;
            else if (m1_cyc_i)        state_d = ARB_GNT1;
         end
         ARB_GNT0: begin
            if (!m0_cyc_i) state_d = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
         end
         ARB_GNT1: begin
            if (!m1_cyc_i) state_d = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Grant register and last-served flop; last-served follows each new grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         last_q  <= LAST_M1;
      end else begin
         state_q <= state_d;
         if (state_d != state_q && state_d == ARB_GNT0) last_q <= LAST_M0;
         if (state_d != state_q && state_d == ARB_GNT1) last_q <= LAST_M1;
      end
   end

   // Granted master's strobe before the watchdog gate.
   assign stb_raw = (state_q == ARB_GNT0) ? m0_stb_i :
                    (state_q == ARB_GNT1) ? m1_stb_i : 1'b0;

   generate
      if (TIMEOUT > 0) begin : g_wd
         logic wd_clr;
         assign wd_clr = (state_d != state_q) || s_ack_i;
         bexkat2_busarb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clr_i     (wd_clr),
            .en_i      (stb_raw),
            .timeout_o (timeout)
         );
      end else begin : g_nowd
         assign timeout = 1'b0;
      end
   endgenerate

   assign gnt_o   = grant_of(state_q);
   assign state_o = state_q;

   // Slave-side mux and master-side ack/err routing from the registered grant.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_sel_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      case (state_q)
         ARB_GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = stb_raw && !timeout;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_sel_o  = m0_sel_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i && !timeout;
            m0_err_o = timeout;
         end
         ARB_GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = stb_raw && !timeout;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_sel_o  = m1_sel_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i && !timeout;
            m1_err_o = timeout;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bexkat2_busarb.sv
// Directed bench for bexkat2_busarb: a TIMEOUT=8 instance (u_dut) and a
// TIMEOUT=0 instance (u_dutz) share all inputs.
module tb_bexkat2_busarb;

   localparam logic [31:0] ADR0 = 32'h1000_0000;
   localparam logic [31:0] ADR1 = 32'h7000_0010;
   localparam logic [31:0] DAT0 = 32'hA0A0_0001;
   localparam logic [31:0] DAT1 = 32'hB1B1_0002;
   localparam logic [31:0] SDAT = 32'hCAFE_F00D;

   logic        clk, rst_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i;
   logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, s_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;

   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [1:0]  gnt_o, state_o;

   logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
   logic        z_m0_ack_o, z_m0_err_o, z_m1_ack_o, z_m1_err_o, z_s_cyc_o, z_s_stb_o, z_s_we_o;
   logic [3:0]  z_s_sel_o;
   logic [1:0]  z_gnt_o, z_state_o;

   int n_vec = 0;
   int n_bad = 0;

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   bexkat2_busarb #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(gnt_o), .state_o(state_o)
   );

   bexkat2_busarb #(.AW(32), .DW(32), .TIMEOUT(0)) u_dutz (
      .clk_i(clk), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o),
      .m0_err_o(z_m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o),
      .m1_err_o(z_m1_err_o),
      .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o), .s_adr_o(z_s_adr_o),
      .s_sel_o(z_s_sel_o), .s_dat_o(z_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(z_gnt_o), .state_o(z_state_o)
   );

   // vector record: inputs {rst,c0,s0,c1,s1,ack}, expected {gnt,scyc,sstb,a0,a1,e0,e1}
   typedef struct packed {
      logic       rst, c0, s0, c1, s1, ack;
      logic [1:0] gnt;
      logic       scyc, sstb, a0, a1, e0, e1;
   } vec_t;

   vec_t tbl[22];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      logic        e_we;
      int          z_bad;

      // reset and constant master payloads
      rst_i = 1'b1; s_ack_i = 1'b0; s_dat_i = SDAT;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 1'b0; m0_adr_i = ADR0; m0_sel_i = 4'hF; m0_dat_i = DAT0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 1'b1; m1_adr_i = ADR1; m1_sel_i = 4'h3; m1_dat_i = DAT1;
      repeat (2) @(posedge clk);

      tbl[0]  = {6'b100000, 8'b00_00_0000}; // reset held: idle
      tbl[1]  = {6'b011110, 8'b00_00_0000}; // both request from reset: nothing yet
      tbl[2]  = {6'b011111, 8'b01_11_1000}; // m0 wins tie, beat 1
      tbl[3]  = {6'b011111, 8'b01_11_1000}; // beat 2, m1 waiting
      tbl[4]  = {6'b011111, 8'b01_11_1000}; // beat 3
      tbl[5]  = {6'b000110, 8'b01_00_0000}; // m0 drops cyc
      tbl[6]  = {6'b000111, 8'b10_11_0100}; // m1 served, m0 sees no ack
      tbl[7]  = {6'b011000, 8'b10_00_0000}; // m1 drops, m0 requests
      tbl[8]  = {6'b011111, 8'b01_11_1000}; // alternation 01
      tbl[9]  = {6'b000110, 8'b01_00_0000};
      tbl[10] = {6'b011111, 8'b10_11_0100}; // alternation 10
      tbl[11] = {6'b011000, 8'b10_00_0000};
      tbl[12] = {6'b011001, 8'b01_11_1000}; // alternation 01
      tbl[13] = {6'b000000, 8'b01_00_0000}; // release to idle
      tbl[14] = {6'b011110, 8'b00_00_0000}; // tie after m0 served -> m1
      tbl[15] = {6'b011111, 8'b10_11_0100};
      tbl[16] = {6'b111110, 8'b10_11_0000}; // reset mid-transfer
      tbl[17] = {6'b111110, 8'b00_00_0000}; // slave cycle dropped
      tbl[18] = {6'b011110, 8'b00_00_0000}; // tie after reset -> m0
      tbl[19] = {6'b011111, 8'b01_11_1000};
      tbl[20] = {6'b000000, 8'b01_00_0000};
      tbl[21] = {6'b000000, 8'b00_00_0000};

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         rst_i = tbl[i].rst; m0_cyc_i = tbl[i].c0; m0_stb_i = tbl[i].s0;
         m1_cyc_i = tbl[i].c1; m1_stb_i = tbl[i].s1; s_ack_i = tbl[i].ack;
         #2;
         e_adr = (tbl[i].gnt == 2'b01) ? ADR0 : (tbl[i].gnt == 2'b10) ? ADR1 : 32'h0;
         e_dat = (tbl[i].gnt == 2'b01) ? DAT0 : (tbl[i].gnt == 2'b10) ? DAT1 : 32'h0;
         e_sel = (tbl[i].gnt == 2'b01) ? 4'hF : (tbl[i].gnt == 2'b10) ? 4'h3 : 4'h0;
         e_we  = (tbl[i].gnt == 2'b10);
         check($sformatf("v%0d_gnt", i),   gnt_o,    tbl[i].gnt);
         check($sformatf("v%0d_state", i), state_o,  tbl[i].gnt);
         check($sformatf("v%0d_scyc", i),  s_cyc_o,  tbl[i].scyc);
         check($sformatf("v%0d_sstb", i),  s_stb_o,  tbl[i].sstb);
         check($sformatf("v%0d_a0", i),    m0_ack_o, tbl[i].a0);
         check($sformatf("v%0d_a1", i),    m1_ack_o, tbl[i].a1);
         check($sformatf("v%0d_e0", i),    m0_err_o, tbl[i].e0);
         check($sformatf("v%0d_e1", i),    m1_err_o, tbl[i].e1);
         check($sformatf("v%0d_adr", i),   s_adr_o,  e_adr);
         check($sformatf("v%0d_sdat", i),  s_dat_o,  e_dat);
         check($sformatf("v%0d_sel", i),   s_sel_o,  e_sel);
         check($sformatf("v%0d_we", i),    s_we_o,   e_we);
         check($sformatf("v%0d_m0dat", i), m0_dat_o, SDAT);
         check($sformatf("v%0d_m1dat", i), m1_dat_o, SDAT);
         check($sformatf("v%0d_zgnt", i),  z_gnt_o,  tbl[i].gnt);
         check($sformatf("v%0d_zstb", i),  z_s_stb_o, tbl[i].sstb);
         check($sformatf("v%0d_za0", i),   z_m0_ack_o, tbl[i].a0);
         check($sformatf("v%0d_za1", i),   z_m1_ack_o, tbl[i].a1);
      end

      // watchdog: m1 read never acked, err on 8th strobe cycle with a late ack suppressed
      @(negedge clk);
      m1_we_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b0;
      #2 check("t4_req_gnt", gnt_o, 2'b00);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         s_ack_i = (k == 8);
         #2;
         check($sformatf("t4_c%0d_gnt", k),  gnt_o,    2'b10);
         check($sformatf("t4_c%0d_cyc", k),  s_cyc_o,  1'b1);
         check($sformatf("t4_c%0d_stb", k),  s_stb_o,  (k != 8));
         check($sformatf("t4_c%0d_err", k),  m1_err_o, (k == 8));
         check($sformatf("t4_c%0d_ack", k),  m1_ack_o, 1'b0);
         check($sformatf("t4_c%0d_we", k),   s_we_o,   1'b0);
         check($sformatf("t4_c%0d_adr", k),  s_adr_o,  ADR1);
         check($sformatf("t4_c%0d_zack", k), z_m1_ack_o, (k == 8));
         check($sformatf("t4_c%0d_zerr", k), z_m1_err_o, 1'b0);
      end
      @(negedge clk);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #2 check("t4_drop_gnt", gnt_o, 2'b10);
      check("t4_drop_err", m1_err_o, 1'b0);
      @(negedge clk);
      #2 check("t4_idle_gnt", gnt_o, 2'b00);
      check("t4_idle_scyc", s_cyc_o, 1'b0);

      // no watchdog: 1000-cycle stall on m0, ack at the end is delivered
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      #2 check("t6_req_zgnt", z_gnt_o, 2'b00);
      z_bad = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         s_ack_i = (k == 1000);
         #2;
         if (k < 1000) begin
            if (z_m0_err_o || z_m0_ack_o || z_gnt_o != 2'b01 || !z_s_stb_o) z_bad++;
         end
      end
      check("t6_stall_hold", z_bad, 0);
      check("t6_zack", z_m0_ack_o, 1'b1);
      check("t6_zerr", z_m0_err_o, 1'b0);
      check("t6_zstb", z_s_stb_o, 1'b1);
      check("t6_wd_err", m0_err_o, 1'b1);
      check("t6_wd_ack", m0_ack_o, 1'b0);
      check("t6_wd_stb", s_stb_o, 1'b0);
      @(negedge clk);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
      @(negedge clk);
      #2 check("t6_end_zgnt", z_gnt_o, 2'b00);
      check("t6_end_gnt", gnt_o, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
